// File: rtl/if_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit:
// FSM encoding, datapath widths and stall-vector bit positions.
package if_fetch_pkg;

  localparam int ADDR_W   = 32;
  localparam int INST_W   = 32;
  localparam int STALL_W  = 6;
  localparam int STALL_IF = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    DONE = 3'd5
  } fetch_state_t;

  // Byte offset from fetch_pc that a read state puts on the memory bus.
  function automatic logic [1:0] rd_offset(input fetch_state_t s);
    case (s)
      RD1:     return 2'd1;
      RD2:     return 2'd2;
      RD3:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_assembler.sv
// Collects returned bytes into a little-endian 32-bit word; the word output already
// includes the byte being written this cycle. Cleared on flush; no backpressure of its own.
module inst_assembler
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [1:0]        idx,
  input  logic [7:0]        din,
  output logic [INST_W-1:0] word
);

  logic [INST_W-1:0] byte_q;

  always_comb begin
    word = byte_q;
    if (we) word[{idx, 3'b000} +: 8] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     byte_q <= '0;
    else if (clr)   byte_q <= '0;
    else if (we)    byte_q <= word;
  end

endmodule

// File: rtl/if_fetch.sv
// Fetches a 32-bit instruction as four byte reads; 6 cycles from acceptance to if_valid_o.
// rdy_in low freezes everything; stall[1] holds DONE and the if_* outputs; branch flushes.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               branch_flag_in,
  input  logic [7:0]         mem_din_i,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_rd_o,
  output logic               stallreq_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [INST_W-1:0]  if_inst_o,
  output logic               if_valid_o
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              cap_we, cap_clr;
  logic [1:0]        cap_idx;
  logic [INST_W-1:0] word;
  logic              unused_stall;

  assign unused_stall = ^{stall[STALL_W-1:STALL_IF+1], stall[STALL_IF-1:0]};
  assign cap_clr      = rdy_in && branch_flag_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Byte k-1 arrives while RDk drives address k; byte 3 arrives in DONE.
  always_comb begin
    state_nxt  = state;
    cap_we     = 1'b0;
    cap_idx    = 2'd0;
    mem_rd_o   = 1'b0;
    mem_addr_o = '0;
    stallreq_o = 1'b0;
    case (state)
      IDLE:    state_nxt = RD0;
      RD0:     state_nxt = RD1;
      RD1:     begin state_nxt = RD2; cap_we = 1'b1; cap_idx = 2'd0; end
      RD2:     begin state_nxt = RD3; cap_we = 1'b1; cap_idx = 2'd1; end
      RD3:     begin state_nxt = DONE; cap_we = 1'b1; cap_idx = 2'd2; end
      DONE:    begin
                 state_nxt = stall[STALL_IF] ? DONE : IDLE;
                 cap_we    = 1'b1;
                 cap_idx   = 2'd3;
               end
      default: state_nxt = IDLE;
    endcase
    if (branch_flag_in) begin
      state_nxt = IDLE;
      cap_we    = 1'b0;
    end
    cap_we = cap_we && rdy_in;
    if (state inside {RD0, RD1, RD2, RD3}) begin
      stallreq_o = 1'b1;
      mem_rd_o   = rdy_in;
      mem_addr_o = fetch_pc + ADDR_W'(rd_offset(state));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc   <= '0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
      if_valid_o <= 1'b0;
    end else if (rdy_in) begin
      if (state == IDLE && !branch_flag_in) fetch_pc <= pc_in;
      if (branch_flag_in) begin
        if_valid_o <= 1'b0;
        if_inst_o  <= '0;
      end else if (!stall[STALL_IF]) begin
        if (state == DONE) begin
          if_pc_o    <= fetch_pc;
          if_inst_o  <= word;
          if_valid_o <= 1'b1;
        end else begin
          if_valid_o <= 1'b0;
        end
      end
    end
  end

  inst_assembler u_asm (
    .clk   (clk_in),
    .rst_n (rst_in),
    .clr   (cap_clr),
    .we    (cap_we),
    .idx   (cap_idx),
    .din   (mem_din_i),
    .word  (word)
  );

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port rdy_in, input, 1; when low, all state is frozen.
REQ-004 SHALL have port stall, input, 6, pipeline stall vector; bit 1 high holds the IF/ID output.
REQ-005 SHALL have port pc_in, input, 32, fetch address from the PC register.
REQ-006 SHALL have port branch_flag_in, input, 1, redirect/flush from EX.
REQ-007 SHALL have port mem_din_i, input, 8, byte returned from memory one cycle after its address.
REQ-008 SHALL have port mem_addr_o, output, 32, byte address to memory.
REQ-009 SHALL have port mem_rd_o, output, 1, memory read strobe.
REQ-010 SHALL have port stallreq_o, output, 1, request to freeze the PC and the front end while a fetch is in flight.
REQ-011 SHALL have port if_pc_o, output, 32, address of the delivered instruction.
REQ-012 SHALL have port if_inst_o, output, 32, delivered instruction.
REQ-013 SHALL have port if_valid_o, output, 1, if_inst_o holds a fresh instruction.

Function
REQ-014 SHALL implement FSM states IDLE, RD0, RD1, RD2, RD3, DONE.
REQ-015 In IDLE, with rdy_in high and no branch_flag_in, SHALL latch pc_in as fetch_pc and go to RD0.
REQ-016 In state RDk (k=0..3), SHALL drive mem_rd_o=1 and mem_addr_o=fetch_pc+k.
REQ-017 In RDk (k>=1) and DONE, SHALL capture mem_din_i into byte k-1 and byte 3 respectively (little-endian; byte0 is inst[7:0]).
REQ-018 In DONE, SHALL load if_pc_o=fetch_pc and if_inst_o=assembled word, assert if_valid_o for one cycle, and return to IDLE.
REQ-019 Latency SHALL be 6 cycles from IDLE acceptance to if_valid_o; back-to-back fetches SHALL yield one instruction per 6 cycles.
REQ-020 stallreq_o SHALL be high in RD0..RD3, and low in IDLE and DONE.
REQ-021 When stall[1] is high in DONE, SHALL hold the FSM in DONE and hold the previous if_* outputs until stall[1] clears.
REQ-022 branch_flag_in high in any state SHALL abort the fetch, discard partial bytes, force if_valid_o=0 and if_inst_o=0 (NOP-equivalent bubble), and go to IDLE; the next fetch starts the following cycle from the redirected pc_in.
REQ-023 When branch_flag_in and DONE coincide, the flush SHALL win and no instruction SHALL be delivered.
REQ-024 When rdy_in is low, SHALL hold the FSM, byte buffer, and outputs; mem_rd_o SHALL be 0 and SHALL resume at the same state.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32 (fetch_pc+3 wraps at 0xFFFFFFFF).
REQ-026 Outside RD0..RD3, mem_rd_o SHALL be 0 and mem_addr_o SHALL be 0.

Reset
REQ-027 rst_in low SHALL immediately force state IDLE, fetch_pc=0, byte buffer=0, if_pc_o=0, if_inst_o=0, if_valid_o=0, mem_rd_o=0, mem_addr_o=0, stallreq_o=0.
REQ-028 Reset asserted mid-fetch SHALL discard the fetch, and the first fetch after release SHALL use pc_in.

Structure
REQ-029 FSM state encoding, 32-bit address/instruction widths, and stall-bit indices SHALL live in the shared defines package.
REQ-030 Byte assembly SHALL be a sub-module inst_assembler (byte index + byte in, 32-bit word out); the FSM stays in if_fetch.

Verification
REQ-031 pc_in=0x00001000, memory bytes 13 05 A0 00 -> if_inst_o=0x00A00513, if_pc_o=0x1000, and if_valid_o pulses in cycle 6; stallreq_o is high for 4 cycles.
REQ-032 branch_flag_in pulses in RD2, then pc_in=0x2000 -> no valid for 0x1000; the next valid is if_pc_o=0x2000 after 6 more cycles.
REQ-033 rdy_in low for 3 cycles during RD1 -> mem_rd_o=0 while low; the final word is unchanged; latency is 9 cycles.
REQ-034 stall[1] high for 2 cycles in DONE -> if_* outputs are held for 2 cycles, with no new fetch started.
REQ-035 rst_in asserted in RD3 -> all outputs are 0 asynchronously; after release, the fetch restarts at the current pc_in.
REQ-036 pc_in=0xFFFFFFFE -> mem_addr_o sequence is FFFFFFFE, FFFFFFFF, 00000000, 00000001.
